// File: rtl/synch_fifo_pkg.sv
// Shared width helpers for the multi-lane synchronous FIFO.
package synch_fifo_pkg;

  function automatic int unsigned clog2(input int unsigned val);
    int unsigned res;
    longint unsigned pow;
    res = 32'd0;
    pow = 64'd1;
    while (pow < longint'(val)) begin
      pow = pow << 1;
      res = res + 32'd1;
    end
    return res;
  endfunction

  // Keep at least one address bit so degenerate depths still elaborate.
  function automatic int unsigned addr_w(input int unsigned depth);
    return (clog2(depth) < 32'd1) ? 32'd1 : clog2(depth);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return clog2(depth + 32'd1);
  endfunction

endpackage

// File: rtl/synch_fifo_mem.sv
// Simple dual-port storage with a registered, read-before-write read port.
module synch_fifo_mem #(
  parameter int unsigned WIDTH  = 32'd100,
  parameter int unsigned DEPTH  = 32'd60,
  parameter int unsigned ADDR_W = 32'd6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read register samples the pre-write contents when addresses collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/synch_fifo_mc.sv
// Multi-lane synchronous FIFO: pointers, occupancy, status flags.
// Optional sticky ovf/udf error flags are enabled by SYNCH_FIFO_ERR_EN.
module synch_fifo_mc
  import synch_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 32'd25,
  parameter int unsigned NUM_CH = 32'd4,
  parameter int unsigned DEPTH  = 32'd60,
  parameter int unsigned AF_LVL = DEPTH - 32'd2,
  parameter int unsigned AE_LVL = 32'd2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [NUM_CH*DATA_W-1:0]   din,
  input  logic                       rd_en,
  output logic [NUM_CH*DATA_W-1:0]   dout,
  output logic                       dout_vld,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [cnt_w(DEPTH)-1:0]    count
`ifdef SYNCH_FIFO_ERR_EN
  ,
  output logic                       ovf,
  output logic                       udf
`endif
);

  localparam int unsigned ADDR_W = addr_w(DEPTH);
  localparam int unsigned CNT_W  = cnt_w(DEPTH);
  localparam int unsigned WIDTH  = NUM_CH * DATA_W;

  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  AF_C     = CNT_W'(AF_LVL);
  localparam logic [CNT_W-1:0]  AE_C     = CNT_W'(AE_LVL);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 32'd1);

  if ((DEPTH < 32'd2) || (AE_LVL >= AF_LVL) || (AF_LVL > DEPTH)) begin : g_param_err
    $error("synch_fifo_mc: illegal DEPTH/AF_LVL/AE_LVL combination");
  end

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              dout_vld_q;
  logic              empty_s, full_s, rd_acc_s, wr_acc_s;

  // Explicit wrap so non-power-of-two depths never index past the array.
  function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
  endfunction

  assign empty_s  = (count_q == '0);
  assign full_s   = (count_q == DEPTH_C);
  assign rd_acc_s = rd_en & ~empty_s;
  assign wr_acc_s = wr_en & (~full_s | rd_en);

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc_s) begin
      wr_ptr_d = next_ptr(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_acc_s) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      dout_vld_q <= rd_acc_s;
    end
  end

  synch_fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_acc_s),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (din),
    .rd_en_i   (rd_acc_s),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (dout)
  );

  assign dout_vld     = dout_vld_q;
  assign count        = count_q;
  assign empty        = empty_s;
  assign full         = full_s;
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

`ifdef SYNCH_FIFO_ERR_EN
  logic ovf_q, udf_q;

  // Sticky error flags; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (wr_en & ~wr_acc_s);
      udf_q <= udf_q | (rd_en & empty_s);
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`endif

endmodule

// File: tb/tb_synch_fifo_mc.sv
// Scoreboard bench for synch_fifo_mc: DEPTH=4 and DEPTH=5 instances, 2 lanes x 8 bits.
module tb_synch_fifo_mc;

  logic        clk = 1'b0;
  logic        rst4, wr4, rd4, rst5, wr5, rd5;
  logic [15:0] din4, din5, dout4, dout5;
  logic        vld4, full4, empty4, af4, ae4;
  logic        vld5, full5, empty5, af5, ae5;
  logic [2:0]  cnt4, cnt5;
  logic        ovf4, udf4, ovf5, udf5;

  int checks = 0;
  int errors = 0;
  logic [15:0] q4[$];
  logic [15:0] q5[$];

  always #5 clk = ~clk;

  synch_fifo_mc #(.DATA_W(8), .NUM_CH(2), .DEPTH(4), .AF_LVL(3), .AE_LVL(1)) u_d4 (
    .clk(clk), .rst(rst4), .wr_en(wr4), .din(din4), .rd_en(rd4), .dout(dout4),
    .dout_vld(vld4), .full(full4), .empty(empty4), .almost_full(af4),
    .almost_empty(ae4), .count(cnt4)
`ifdef SYNCH_FIFO_ERR_EN
    , .ovf(ovf4), .udf(udf4)
`endif
  );

  synch_fifo_mc #(.DATA_W(8), .NUM_CH(2), .DEPTH(5), .AE_LVL(2)) u_d5 (
    .clk(clk), .rst(rst5), .wr_en(wr5), .din(din5), .rd_en(rd5), .dout(dout5),
    .dout_vld(vld5), .full(full5), .empty(empty5), .almost_full(af5),
    .almost_empty(ae5), .count(cnt5)
`ifdef SYNCH_FIFO_ERR_EN
    , .ovf(ovf5), .udf(udf5)
`endif
  );

`ifndef SYNCH_FIFO_ERR_EN
  assign ovf4 = 1'b0;
  assign udf4 = 1'b0;
  assign ovf5 = 1'b0;
  assign udf5 = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Expected-count/full/empty/af/ae packed as one status compare.
  task automatic st4(input string tag, input logic [2:0] c, input logic f, input logic e,
                     input logic af, input logic ae);
    chk({tag, ".d4_status"}, {cnt4, full4, empty4, af4, ae4}, {c, f, e, af, ae});
  endtask

  task automatic st5(input string tag, input logic [2:0] c, input logic f, input logic e,
                     input logic af, input logic ae);
    chk({tag, ".d5_status"}, {cnt5, full5, empty5, af5, ae5}, {c, f, e, af, ae});
  endtask

  task automatic cyc4(input logic r, input logic w, input logic rd, input logic [15:0] d,
                      input bit push, input logic [15:0] e);
    rst4 = r; wr4 = w; rd4 = rd; din4 = d;
    if (push) q4.push_back(e);
    @(posedge clk); #1;
    rst4 = 1'b0; wr4 = 1'b0; rd4 = 1'b0;
  endtask

  task automatic cyc5(input logic w, input logic rd, input logic [15:0] d,
                      input bit push, input logic [15:0] e);
    wr5 = w; rd5 = rd; din5 = d;
    if (push) q5.push_back(e);
    @(posedge clk); #1;
    wr5 = 1'b0; rd5 = 1'b0;
  endtask

  // Monitors: every dout_vld pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (vld4) begin
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL d4.unexpected_vld actual=%0h expected=no_read", dout4);
      end else if (dout4 !== q4[0]) begin
        errors++;
        $display("FAIL d4.dout actual=%0h expected=%0h", dout4, q4[0]);
        void'(q4.pop_front());
      end else begin
        void'(q4.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (vld5) begin
      checks++;
      if (q5.size() == 0) begin
        errors++;
        $display("FAIL d5.unexpected_vld actual=%0h expected=no_read", dout5);
      end else if (dout5 !== q5[0]) begin
        errors++;
        $display("FAIL d5.dout actual=%0h expected=%0h", dout5, q5[0]);
        void'(q5.pop_front());
      end else begin
        void'(q5.pop_front());
      end
    end
  end

  initial begin
    rst4 = 1'b0; wr4 = 1'b0; rd4 = 1'b0; din4 = 16'h0000;
    rst5 = 1'b1; wr5 = 1'b0; rd5 = 1'b0; din5 = 16'h0000;
    cyc4(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    rst5 = 1'b0;
    st4("reset", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("reset.dout", dout4, 32'h0);
    chk("reset.vld", vld4, 32'h0);
    st5("reset", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Fill in order; flags at each level.
    cyc4(1'b0, 1'b1, 1'b0, 16'h0100, 1'b0, 16'h0); st4("fill1", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc4(1'b0, 1'b1, 1'b0, 16'h0302, 1'b0, 16'h0); st4("fill2", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc4(1'b0, 1'b1, 1'b0, 16'h0504, 1'b0, 16'h0); st4("fill3", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc4(1'b0, 1'b1, 1'b0, 16'h0706, 1'b0, 16'h0); st4("fill4", 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);

    // Full with both requests: old head comes out, new word goes in.
    cyc4(1'b0, 1'b1, 1'b1, 16'h0908, 1'b1, 16'h0100);
    st4("full_rw", 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("full_rw.ovf", ovf4, 32'h0);

    cyc4(1'b0, 1'b0, 1'b1, 16'h0, 1'b1, 16'h0302); st4("drain1", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc4(1'b0, 1'b0, 1'b1, 16'h0, 1'b1, 16'h0504); st4("drain2", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc4(1'b0, 1'b0, 1'b1, 16'h0, 1'b1, 16'h0706); st4("drain3", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc4(1'b0, 1'b0, 1'b1, 16'h0, 1'b1, 16'h0908); st4("drain4", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);

    cyc4(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    chk("hold.dout", dout4, 32'h0908);
    chk("hold.vld", vld4, 32'h0);

    // Empty with both requests: write only, read rejected.
    cyc4(1'b0, 1'b1, 1'b1, 16'h0A0A, 1'b0, 16'h0);
    st4("empty_rw", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("empty_rw.vld", vld4, 32'h0);
    chk("empty_rw.dout", dout4, 32'h0908);
`ifdef SYNCH_FIFO_ERR_EN
    chk("empty_rw.udf", udf4, 32'h1);
`endif
    cyc4(1'b0, 1'b0, 1'b1, 16'h0, 1'b1, 16'h0A0A); st4("empty_rw_rd", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Overflow: lone write at full is dropped.
    cyc4(1'b0, 1'b1, 1'b0, 16'h1111, 1'b0, 16'h0);
    cyc4(1'b0, 1'b1, 1'b0, 16'h2222, 1'b0, 16'h0);
    cyc4(1'b0, 1'b1, 1'b0, 16'h3333, 1'b0, 16'h0);
    cyc4(1'b0, 1'b1, 1'b0, 16'h4444, 1'b0, 16'h0);
    cyc4(1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b0, 16'h0);
    st4("ovf_drop", 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef SYNCH_FIFO_ERR_EN
    chk("ovf.set", ovf4, 32'h1);
`endif
    cyc4(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
`ifdef SYNCH_FIFO_ERR_EN
    chk("ovf.sticky", ovf4, 32'h1);
`endif
    cyc4(1'b0, 1'b0, 1'b1, 16'h0, 1'b1, 16'h1111);
    cyc4(1'b0, 1'b0, 1'b1, 16'h0, 1'b1, 16'h2222);
    cyc4(1'b0, 1'b0, 1'b1, 16'h0, 1'b1, 16'h3333);
    cyc4(1'b0, 1'b0, 1'b1, 16'h0, 1'b1, 16'h4444);
    st4("ovf_drain", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc4(1'b0, 1'b0, 1'b1, 16'h0, 1'b0, 16'h0);
    chk("udf_read.vld", vld4, 32'h0);
    st4("udf_read", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Reset mid-stream beats a concurrent write.
    cyc4(1'b0, 1'b1, 1'b0, 16'h5555, 1'b0, 16'h0);
    cyc4(1'b0, 1'b0, 1'b1, 16'h0, 1'b1, 16'h5555);
    cyc4(1'b0, 1'b1, 1'b0, 16'h5A5A, 1'b0, 16'h0);
    st4("pre_rst", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc4(1'b1, 1'b1, 1'b0, 16'h6666, 1'b0, 16'h0);
    st4("mid_rst", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("mid_rst.dout", dout4, 32'h0);
    chk("mid_rst.vld", vld4, 32'h0);
    chk("mid_rst.err", {ovf4, udf4}, 32'h0);
    cyc4(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    st4("post_rst", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc4(1'b0, 1'b1, 1'b0, 16'h7777, 1'b0, 16'h0);
    cyc4(1'b0, 1'b0, 1'b1, 16'h0, 1'b1, 16'h7777);

    // DEPTH=5 streaming at count 2: pointers wrap several times.
    cyc5(1'b1, 1'b0, 16'hA000, 1'b0, 16'h0);
    cyc5(1'b1, 1'b0, 16'hA001, 1'b0, 16'h0);
    for (int i = 2; i < 12; i++) begin
      cyc5(1'b1, 1'b1, 16'hA000 + 16'(i), 1'b1, 16'hA000 + 16'(i - 2));
      st5("stream", 3'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    cyc5(1'b0, 1'b1, 16'h0, 1'b1, 16'hA00A);
    cyc5(1'b0, 1'b1, 16'h0, 1'b1, 16'hA00B);
    st5("stream_end", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);

    // DEPTH=5 fill to full across the wrap point, then overflow attempt.
    for (int i = 0; i < 5; i++) begin
      cyc5(1'b1, 1'b0, 16'hB000 + 16'(i), 1'b0, 16'h0);
    end
    st5("d5_full", 3'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc5(1'b1, 1'b0, 16'hFFFF, 1'b0, 16'h0);
    st5("d5_ovf", 3'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc5(1'b0, 1'b1, 16'h0, 1'b1, 16'hB000 + 16'(i));
    end
    st5("d5_drain", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("d4.pending_reads", q4.size(), 32'h0);
    chk("d5.pending_reads", q5.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
